histogram_banked: RTL

//  Parametrised streaming grey-level histogram for the video path: counts NUM_BANKS-way

---
 rtl/histogram_banked.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/histogram_banked.sv
// Banked streaming grey-level histogram: round-robin bank accumulation per frame,
// then an ordered, clear-on-read bin dump summed across banks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zero every address of every bank, one address per cycle
// S_ACCUM | count accepted pixels into bank[bank_ptr]
// S_DRAIN | two cycles letting the last read-modify-write land
// S_READY | histogram complete, waiting for a readout request
// S_READ  | issue bins 0..max, emit summed counts, zero each address
module histogram_banked #(
  parameter int PIX_W     = 8,
  parameter int CNT_W     = 20,
  parameter int NUM_BANKS = 3,
  parameter int TOT_W     = 24
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [PIX_W-1:0] iGray,
  input  logic             iValid,
  input  logic             iFrameEnd,
  input  logic             iRdReq,
  output logic             oBusy,
  output logic             oDone,
  output logic [PIX_W-1:0] oBin,
  output logic [CNT_W-1:0] oCount,
  output logic             oCountValid,
  output logic [TOT_W-1:0] oTotal,
  output logic [TOT_W-1:0] oDropped
);

  localparam int NBINS  = 2**PIX_W;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int SUM_W  = CNT_W + BANK_W;
  localparam logic [PIX_W-1:0]  LAST_BIN  = '1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [SUM_W-1:0]  CNT_MAX   = {{BANK_W{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_READY,
    S_READ
  } state_t;

  state_t              r_state;
  logic [PIX_W-1:0]    r_clr_addr;
  logic [PIX_W-1:0]    r_rd_addr;
  logic                r_issuing;
  logic                r_drain_cnt;
  logic [BANK_W-1:0]   r_bank_ptr;

  logic                r_s1_acc;
  logic                r_s1_rdv;
  logic [PIX_W-1:0]    r_s1_addr;
  logic [BANK_W-1:0]   r_s1_bank;

  logic                r_done;
  logic [PIX_W-1:0]    r_bin;
  logic [CNT_W-1:0]    r_count;
  logic                r_cnt_valid;
  logic [TOT_W-1:0]    r_total;
  logic [TOT_W-1:0]    r_dropped;

  logic                w_acc_hit;
  logic                w_issue;
  logic [PIX_W-1:0]    w_rd_addr;
  logic [CNT_W-1:0]    w_rd_data [NUM_BANKS];
  logic [CNT_W-1:0]    w_sel;
  logic [CNT_W-1:0]    w_inc;
  logic [NUM_BANKS-1:0] w_we;
  logic [PIX_W-1:0]    w_wa;
  logic [CNT_W-1:0]    w_wd;
  logic [SUM_W-1:0]    w_sum;
  logic [CNT_W-1:0]    w_sum_sat;

  assign w_acc_hit = (r_state == S_ACCUM) && iValid;
  assign w_issue   = (r_state == S_READ) && r_issuing;
  // All banks share one read address: the pixel value while counting, the bin while reading.
  assign w_rd_addr = w_issue ? r_rd_addr : iGray;

  assign w_sel = w_rd_data[r_s1_bank];
  assign w_inc = (&w_sel) ? w_sel : w_sel + CNT_W'(1);

  always_comb begin
    w_we = '0;
    w_wa = r_s1_addr;
    w_wd = '0;
    if ((r_state == S_CLEAR) && !iRst) begin
      w_we = '1;
      w_wa = r_clr_addr;
    end else if (r_s1_rdv) begin
      w_we = '1;
    end else if (r_s1_acc) begin
      w_we[r_s1_bank] = 1'b1;
      w_wd            = w_inc;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_sum = w_sum + SUM_W'(w_rd_data[b]);
    end
  end

  assign w_sum_sat = (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [CNT_W-1:0] r_mem [NBINS];
    logic [CNT_W-1:0] r_q;

    always_ff @(posedge iClk) begin
      r_q <= r_mem[w_rd_addr];
      if (w_we[b]) begin
        r_mem[w_wa] <= w_wd;
      end
    end

    assign w_rd_data[b] = r_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_rd_addr   <= '0;
      r_issuing   <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_bank_ptr  <= '0;
      r_s1_acc    <= 1'b0;
      r_s1_rdv    <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_bank   <= '0;
      r_done      <= 1'b0;
      r_bin       <= '0;
      r_count     <= '0;
      r_cnt_valid <= 1'b0;
      r_total     <= '0;
      r_dropped   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_s1_acc  <= w_acc_hit;
      r_s1_rdv  <= w_issue;
      r_s1_addr <= w_rd_addr;
      r_s1_bank <= r_bank_ptr;

      if (r_s1_rdv) begin
        r_cnt_valid <= 1'b1;
        r_bin       <= r_s1_addr;
        r_count     <= w_sum_sat;
      end else begin
        r_cnt_valid <= 1'b0;
      end

      if (iValid && (r_state != S_ACCUM) && !(&r_dropped)) begin
        r_dropped <= r_dropped + TOT_W'(1);
      end

      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + PIX_W'(1);
          if (r_clr_addr == LAST_BIN) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_bank_ptr <= (r_bank_ptr == LAST_BANK) ? '0 : r_bank_ptr + BANK_W'(1);
          if (iValid && !(&r_total)) begin
            r_total <= r_total + TOT_W'(1);
          end
          if (iFrameEnd) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_state <= S_READY;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        S_READY: begin
          if (iRdReq) begin
            r_state   <= S_READ;
            r_rd_addr <= '0;
            r_issuing <= 1'b1;
          end
        end
        S_READ: begin
          if (r_issuing) begin
            r_rd_addr <= r_rd_addr + PIX_W'(1);
            if (r_rd_addr == LAST_BIN) begin
              r_issuing <= 1'b0;
            end
          end
          // Leave only once the last bin has actually been presented.
          if (r_cnt_valid && (r_bin == LAST_BIN)) begin
            r_state <= S_ACCUM;
            r_total <= '0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign oBusy       = (r_state == S_CLEAR) || (r_state == S_DRAIN) || (r_state == S_READ);
  assign oDone       = r_done;
  assign oBin        = r_bin;
  assign oCount      = r_count;
  assign oCountValid = r_cnt_valid;
  assign oTotal      = r_total;
  assign oDropped    = r_dropped;

endmodule
